// File: rtl/dmem_rsp_pkg.sv
// rtl/dmem_rsp_pkg.sv - shared types and helpers for the data-memory responder
package dmem_rsp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RWAIT = 2'd1,
    WRSP  = 2'd2,
    RRSP  = 2'd3
  } state_e;

  // Full word-index width carried through the write buffer (req_addr[31:2])
  localparam int WIDX_W = 30;

  typedef struct packed {
    logic [WIDX_W-1:0] idx;
    logic [31:0]       data;
  } wbuf_entry_t;

  // Bits needed to index `depth` items; never less than one bit
  function automatic int idx_width(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

endpackage

// File: rtl/dmem_rsp_wbuf.sv
// rtl/dmem_rsp_wbuf.sv - posted-write FIFO with youngest-hit address lookup
module dmem_rsp_wbuf
  import dmem_rsp_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  wbuf_entry_t       push_entry_i,
  input  logic [WIDX_W-1:0] lookup_idx_i,
  output logic              hit_o,
  output logic [31:0]       hit_data_o,
  output logic              drain_valid_o,
  output wbuf_entry_t       drain_entry_o,
  output logic              full_o
);

  localparam int PW = idx_width(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  wbuf_entry_t   entries_q [DEPTH];

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // The oldest entry leaves every cycle the buffer is non-empty
  assign drain_valid_o = (count_q != '0);
  assign drain_entry_o = entries_q[head_q];
  assign full_o        = (count_q == CW'(DEPTH));

  // Pointer and occupancy next-state; push and drain together keep the count
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) tail_d = ptr_inc(tail_q);
    if (drain_valid_o) head_d = ptr_inc(head_q);
    case ({push_i, drain_valid_o})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer/occupancy registers; reset discards every buffered write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage needs no reset; validity comes from the occupancy count
  always_ff @(posedge clk) begin
    if (push_i) entries_q[tail_q] <= push_entry_i;
  end

  // Walk entries oldest to youngest so the youngest match wins
  always_comb begin : lookup
    int p;
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int k = 0; k < DEPTH; k++) begin
      p = int'(head_q) + k;
      if (p >= DEPTH) p = p - DEPTH;
      if ((k < int'(count_q)) && (entries_q[PW'(p)].idx == lookup_idx_i)) begin
        hit_o      = 1'b1;
        hit_data_o = entries_q[PW'(p)].data;
      end
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle data-memory responder; DMEM_RSP_ERR_EN enables address error checking
module dmem_responder
  import dmem_rsp_pkg::*;
#(
  parameter int DEPTH_WORDS = 64,
  parameter int RD_LATENCY  = 2,
  parameter int WBUF_DEPTH  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IW    = idx_width(DEPTH_WORDS);
  localparam int CNT_W = idx_width(RD_LATENCY);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
  logic [31:0]       mem_q [DEPTH_WORDS];

  logic [WIDX_W-1:0] word_idx;
  logic              req_err;
  logic              accept, push;
  logic              wbuf_full, hit, drain_valid;
  logic [31:0]       hit_data, merged_data;
  wbuf_entry_t       drain_entry;

`ifdef DMEM_RSP_ERR_EN
  assign word_idx = req_addr[31:2];
  assign req_err  = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= WIDX_W'(DEPTH_WORDS));
`else
  logic addr_lsb_unused;
  assign word_idx        = req_addr[31:2] % WIDX_W'(DEPTH_WORDS);
  assign req_err         = 1'b0;
  assign addr_lsb_unused = ^req_addr[1:0];
`endif

  assign req_ready = (state_q == IDLE) && !wbuf_full;
  assign accept    = req_valid && req_ready;
  assign push      = accept && req_we && !req_err;

  dmem_rsp_wbuf #(.DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk           (clk),
    .reset         (reset),
    .push_i        (push),
    .push_entry_i  ('{idx: word_idx, data: req_wdata}),
    .lookup_idx_i  (word_idx),
    .hit_o         (hit),
    .hit_data_o    (hit_data),
    .drain_valid_o (drain_valid),
    .drain_entry_o (drain_entry),
    .full_o        (wbuf_full)
  );

  if (IW < WIDX_W) begin : g_drain_hi
    logic drain_hi_unused;
    assign drain_hi_unused = ^drain_entry.idx[WIDX_W-1:IW];
  end

  // Merged view at load acceptance: youngest buffered write, then the draining entry, then the array
  always_comb begin
    if (hit) begin
      merged_data = hit_data;
    end else if (drain_valid && (drain_entry.idx == word_idx)) begin
      merged_data = drain_entry.data;
    end else begin
      merged_data = mem_q[word_idx[IW-1:0]];
    end
  end

  // Background drain of the oldest buffered write into the unreset word array
  always_ff @(posedge clk) begin
    if (drain_valid) mem_q[drain_entry.idx[IW-1:0]] <= drain_entry.data;
  end

  // FSM and response-data registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Next-state: one request in flight; loads wait RD_LATENCY-1 cycles in RWAIT
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          err_d = req_err;
          if (req_we) begin
            state_d = WRSP;
          end else begin
            rdata_d = req_err ? 32'd0 : merged_data;
            if (RD_LATENCY > 1) begin
              state_d = RWAIT;
              cnt_d   = CNT_W'((RD_LATENCY > 1) ? RD_LATENCY - 2 : 0);
            end else begin
              state_d = RRSP;
            end
          end
        end
      end
      RWAIT: begin
        if (cnt_q == '0) state_d = RRSP;
        else cnt_d = cnt_q - 1'b1;
      end
      WRSP:    state_d = IDLE;
      RRSP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign rsp_valid = (state_q == WRSP) || (state_q == RRSP);
  assign rsp_rdata = (state_q == RRSP) ? rdata_q : 32'd0;
  assign rsp_err   = rsp_valid && err_q;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Memory-side responder for the single-cycle ARM core's data bus. Accepts one load/store request at a time over a valid/ready handshake and returns exactly one response per request: stores after 1 cycle, loads after a programmable latency. Stores are posted into a small write buffer that drains into the word array in the background, and loads forward from that buffer. It replaces the zero-latency data memory when multi-cycle memory timing is needed.

## Interface
- DEPTH_WORDS, 64: word-array depth; legal word index 0..DEPTH_WORDS-1
- RD_LATENCY, 2: cycles from load acceptance to response; legal values are 1 and above
- WBUF_DEPTH, 2: posted-write buffer entries; legal values are 1 and above
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  responder can accept
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_wdata  in  32  store data
- rsp_valid  out  1  single-cycle response pulse; no backpressure
- rsp_rdata  out  32  load data; 0 for stores and for errors
- rsp_err  out  1  request rejected; qualified by rsp_valid

## Operation
- Accept occurs on a cycle where req_valid & req_ready.
- req_ready = (state==IDLE) & ~wbuf_full. It does not depend on req_we or any other req_* input.
- Only one request is outstanding at a time.
- FSM states:
  - IDLE: on a store accept, go to WRSP. On a load accept, go to RWAIT if RD_LATENCY>1, else to RRSP.
  - RWAIT: count down RD_LATENCY-1 cycles, then go to RRSP.
  - WRSP: pulse rsp_valid, then go to IDLE.
  - RRSP: pulse rsp_valid, then go to IDLE.
- Store accept: push {word index, wdata} into the write buffer. The word array is untouched at this point.
- Load data is captured at acceptance as the merged view. Source priority:
  1. Youngest matching write-buffer entry.
  2. Else an entry draining this cycle to the same word.
  3. Else the array.
- Load data is held in a register until RRSP.
- Drain: when the buffer is non-empty, the oldest entry is written to the array every cycle. Drain is independent of FSM state.
- Simultaneous push and drain are allowed; occupancy stays unchanged.
- The buffer is full when occupancy == WBUF_DEPTH. While full, req_ready is low until the next drain.
- The word array is not reset. Content is defined only after a write.
- Word index = req_addr[31:2] (bit width clog2(DEPTH_WORDS) after range check).

## Timing
- Reset values: req_ready=1 (IDLE, buffer empty), rsp_valid=0, rsp_rdata=0, rsp_err=0.
- Store accepted at cycle T: rsp_valid at T+1, and req_ready is high again at T+2 (if the buffer is not full).
- Load accepted at cycle T: rsp_valid at T+RD_LATENCY, and req_ready is high at T+RD_LATENCY+1.
- A store's data reaches the array no earlier than T+1. Loads always observe it through forwarding.
- Reset asserted mid-operation:
  - The outstanding response is dropped.
  - Buffered writes are discarded and never reach the array.
  - The FSM returns to IDLE immediately.
  - All outputs take their reset values asynchronously.

## Configuration
- DMEM_RSP_ERR_EN defined:
  - A request is an error if req_addr[1:0]!=0 or req_addr[31:2]>=DEPTH_WORDS.
  - An error store is not pushed into the buffer.
  - An error load returns rsp_rdata=0.
  - Either kind responds with rsp_err=1 at normal latency.
- DMEM_RSP_ERR_EN undefined:
  - req_addr[1:0] is ignored.
  - The word index wraps modulo DEPTH_WORDS.
  - rsp_err is tied to 0.
  - No comparator logic is generated.

## Structure
- Package dmem_rsp_pkg contains:
  - state enum {IDLE, RWAIT, WRSP, RRSP}
  - wbuf entry struct {idx, data}
  - function that computes the index width
- Sub-module dmem_rsp_wbuf: circular FIFO of WBUF_DEPTH entries with head/tail pointers and a count.
  - Provides a parallel address-match lookup that returns the youngest hit.
  - Exposes its drain port to the parent, which owns the array.

## Test plan
- Store 0x7 to address 0x64, then load 0x64 immediately: rsp_valid at T+1 for the store; the load returns 0x7 at its T+2 via forwarding; the array word at index 25 equals 0x7 afterwards.
- Two stores to the same word, 0x60←0xA then 0x60←0xB, followed by a load of 0x60: the load returns 0xB (youngest-entry priority).
- WBUF_DEPTH=1 with back-to-back stores: req_ready stays low until the first entry drains; no entry is lost; the final array contents match.
- RD_LATENCY=3, load 0x04: rsp_valid is low at T+1 and T+2, high at T+3, and low again at T+4.
- With DMEM_RSP_ERR_EN, store to 0x102 (misaligned) and load 0x400 (out of range): both respond with rsp_err=1 and rsp_rdata=0; the array is unchanged.
- Reset asserted during RWAIT with 2 buffered stores: no rsp_valid pulse; after release req_ready=1; a load of those words does not return the discarded data.
